// File: rtl/cpu_wb_master_pkg.sv
// Shared definitions for the CPU-side Wishbone master: state encodings,
// the reset level and the word-address helper.
package cpu_wb_master_pkg;

    typedef enum logic [1:0] {
        WbIdle = 2'd0,
        WbBusy = 2'd1,
        WbDone = 2'd2
    } wb_state_e;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b0;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_wb_master_wb_timeout_cnt.sv
// Watchdog for an outstanding Wishbone cycle: counts BUSY cycles without ack
// and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module wb_timeout_cnt
    import cpu_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic timeout
);

    localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RstEnable)
            cnt <= 8'd0;
        else if (start)
            cnt <= 8'd0;
        else if (busy && !ack)
            cnt <= cnt + 8'd1;
    end

    // cnt holds the ack-less BUSY cycles already elapsed, so this one is the Nth
    assign timeout = busy && (cnt == LastCnt);

endmodule

// File: rtl/cpu_wb_master.sv
// MiniMIPS32 data port to Wishbone classic single-cycle master with pipeline stall.
// Optional watchdog abort is built when WB_TIMEOUT_EN is defined.
module cpu_wb_master
    import cpu_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    wb_state_e state, state_nxt;
    logic      req;
    logic      timeout;

    // Reset also masks the request so stall drops with cyc while reset is held
    assign req = cpu_ce_i && !flush_i && (wb_rst_i != RstEnable);

`ifdef WB_TIMEOUT_EN
    wb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (state == WbIdle && req),
        .busy     (state == WbBusy),
        .ack      (wb_ack_i),
        .timeout  (timeout)
    );
`else
    // No watchdog: only a zero limit (outside the legal range) could ever fire
    assign timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RstEnable)
            state <= WbIdle;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WbIdle:  if (req) state_nxt = WbBusy;
            WbBusy:  if (wb_ack_i || timeout) state_nxt = WbDone;
            WbDone:  state_nxt = WbIdle;
            default: state_nxt = WbIdle;
        endcase
    end

    always_comb begin
        stall_req_o = 1'b0;
        case (state)
            WbIdle:  stall_req_o = req;
            WbBusy:  stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    // Bus fields launch on the request edge and stay put until the next one
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RstEnable) begin
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= ZeroWord;
            wb_sel_o   <= 4'h0;
            wb_dat_o   <= ZeroWord;
            cpu_data_o <= ZeroWord;
            bus_err_o  <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                WbIdle: begin
                    if (req) begin
                        wb_cyc_o <= 1'b1;
                        wb_we_o  <= cpu_we_i;
                        wb_adr_o <= word_addr(cpu_addr_i);
                        wb_sel_o <= cpu_sel_i;
                        wb_dat_o <= cpu_data_i;
                    end
                end
                WbBusy: begin
                    // Ack beats a watchdog expiry landing in the same cycle
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        if (!wb_we_o) cpu_data_o <= wb_dat_i;
                    end else if (timeout) begin
                        wb_cyc_o  <= 1'b0;
                        bus_err_o <= 1'b1;
                        if (!wb_we_o) cpu_data_o <= ZeroWord;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_stb_o = wb_cyc_o;

endmodule

// File: tb/tb_cpu_wb_master.sv
// Randomized transaction-level bench for cpu_wb_master with a scripted wait-state slave.
module tb_cpu_wb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, we, flush;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
    logic        stall, bus_err, cyc, stb, wb_we_o, ack;
    logic [3:0]  wb_sel_o;

    int          slv_wait = 0;
    int          slv_cnt  = 0;
    bit          slv_en   = 1'b0;
    bit          slv_force = 1'b0;
    logic [31:0] slv_rdata = '0;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = '0;

    always #5 clk = ~clk;

    cpu_wb_master #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .cpu_ce_i    (ce),
        .cpu_we_i    (we),
        .cpu_addr_i  (addr),
        .cpu_sel_i   (sel),
        .cpu_data_i  (data),
        .flush_i     (flush),
        .cpu_data_o  (cpu_data_o),
        .stall_req_o (stall),
        .bus_err_o   (bus_err),
        .wb_cyc_o    (cyc),
        .wb_stb_o    (stb),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (slv_rdata),
        .wb_ack_i    (ack)
    );

    // Slave acks once it has seen slv_wait wait-state cycles of the current cycle
    assign ack = slv_force | (slv_en & cyc & (slv_cnt >= slv_wait));

    always @(posedge clk) begin
        if (!cyc || ack) slv_cnt <= 0;
        else             slv_cnt <= slv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One CPU access: request held until stall drops, then withdrawn the cycle after
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] rd, input int wt,
                        input bit fl_mid);
        int ncyc = 0, nstall = 0, nack = 0;
        slv_wait = wt; slv_en = 1'b1; slv_rdata = rd;
        @(posedge clk); #1;
        ce = 1'b1; we = w; addr = a; sel = s; data = d; flush = 1'b0;
        for (int c = 0; c <= wt + 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (fl_mid) flush = 1'b1;
            end
            #1;
            if (stall) nstall++;
            if (cyc) begin
                ncyc++;
                if (ack) nack++;
                chk("wb_we", wb_we_o, w);
                chk("wb_adr", wb_adr_o, a & 32'hFFFF_FFFC);
                chk("wb_sel", wb_sel_o, s);
                chk("wb_dat", wb_dat_o, d);
            end
            chk("stb_eq_cyc", stb, cyc);
            chk("no_bus_err", bus_err, 1'b0);
            if (c == wt + 2) chk("cpu_data", cpu_data_o, w ? exp_rd : rd);
        end
        if (!w) exp_rd = rd;
        @(posedge clk); #1;
        ce = 1'b0; flush = 1'b0;
        #1;
        chk("after_cyc", cyc, 1'b0);
        chk("after_stall", stall, 1'b0);
        chk("cyc_cycles", ncyc, wt + 1);
        chk("stall_cycles", nstall, wt + 2);
        chk("ack_count", nack, 1);
    endtask

    initial begin
        int ncyc, nerr;
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; flush = 1'b0;
        addr = '0; data = '0; sel = '0;
        #2;
        chk("rst_cyc", cyc, 1'b0);
        chk("rst_stb", stb, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_we", wb_we_o, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: combinational-ack read, write, wait states, flush mid-BUSY
        xfer(1'b0, 32'h0000_f020, 4'hf, 32'h0, 32'h0000_00A5, 0, 1'b0);
        xfer(1'b1, 32'h0000_f000, 4'hf, 32'h0000_BEEF, 32'hDEAD_0001, 0, 1'b0);
        xfer(1'b0, 32'h0000_f024, 4'h3, 32'h0, 32'h1234_5678, 3, 1'b0);
        xfer(1'b1, 32'h0000_f008, 4'hc, 32'hCAFE_F00D, 32'h0, 3, 1'b0);
        xfer(1'b1, 32'h0000_f00c, 4'hf, 32'h5555_AAAA, 32'h0, 3, 1'b1);

        // Flush in IDLE blocks the request entirely
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("flush_idle_stall", stall, 1'b0);
            chk("flush_idle_cyc", cyc, 1'b0);
            @(posedge clk); #1;
        end
        ce = 1'b0; flush = 1'b0;

        // Stray ack outside BUSY must not touch the read register
        slv_force = 1'b1; slv_rdata = 32'hFFFF_0000 ^ exp_rd;
        repeat (2) @(posedge clk);
        #2;
        chk("stray_ack_data", cpu_data_o, exp_rd);
        chk("stray_ack_cyc", cyc, 1'b0);
        slv_force = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rdat, rrd;
            ra = $urandom; rdat = $urandom; rrd = $urandom;
            xfer(1'($urandom_range(0, 1)), ra, 4'($urandom_range(1, 15)), rdat, rrd,
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Slave never acks
        slv_en = 1'b0; slv_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = 32'h0000_f030; sel = 4'hf;
`ifdef WB_TIMEOUT_EN
        ncyc = 0; nerr = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 6) ce = 1'b0;
            end
            #1;
            if (cyc) ncyc++;
            if (bus_err) nerr++;
            if (c == 5) begin
                chk("to_err_pulse", bus_err, 1'b1);
                chk("to_data_zero", cpu_data_o, 32'h0);
                chk("to_stall", stall, 1'b0);
            end
        end
        chk("to_cyc_cycles", ncyc, 4);
        chk("to_err_cycles", nerr, 1);
        exp_rd = 32'h0;
`else
        ncyc = 0; nerr = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (cyc) ncyc++;
            if (bus_err) nerr++;
        end
        chk("hang_cyc_cycles", ncyc, 20);
        chk("hang_no_err", nerr, 0);
        chk("hang_stall", stall, 1'b1);
        @(posedge clk); #1;
        slv_en = 1'b1; slv_wait = 0;
        @(posedge clk); #2;
        chk("hang_release_data", cpu_data_o, 32'h7777_7777);
        chk("hang_release_stall", stall, 1'b0);
        exp_rd = 32'h7777_7777;
        @(posedge clk); #1;
        ce = 1'b0;
`endif

        // Reset during BUSY: bus and stall drop without waiting for a clock
        slv_en = 1'b0;
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = 32'h0000_f040;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_cyc", cyc, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", cyc, 1'b0);
        chk("midrst_stb", stb, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_data", cpu_data_o, 32'h0);
        exp_rd = 32'h0;
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(1'b0, 32'h0000_f044, 4'hf, 32'h0, 32'h0BAD_BEEF, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cpu_wb_master.md
# cpu_wb_master

Wishbone bus master that turns the MiniMIPS32 data-memory port into single Wishbone classic read and write cycles toward the peripheral decoder and other slaves. It holds the CPU pipeline with a stall request while a cycle is outstanding. It registers the read data and releases the pipeline for exactly one cycle per completed transfer. It sits between the CPU core's MEM stage and the system Wishbone interconnect.

## Interface
- TIMEOUT_CYCLES, 255: cycles without `wb_ack_i` before a cycle is aborted. Only used when `WB_TIMEOUT_EN` is defined; range 1..255.
- wb_clk_i  in  1  clock; single clock domain
- wb_rst_i  in  1  reset, asynchronous, active-low (`RstEnable` = 0)
- cpu_ce_i  in  1  CPU requests a data access; request fields held stable while `stall_req_o`=1
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lanes
- cpu_data_i  in  32  write data
- flush_i  in  1  pipeline flush (exception); suppresses new requests
- cpu_data_o  out  32  registered read data
- stall_req_o  out  1  hold pipeline
- bus_err_o  out  1  one-cycle pulse on timeout abort
- wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always driven equal
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  `{cpu_addr_i[31:2],2'b00}`
- wb_sel_o  out  4  byte select
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data from slave
- wb_ack_i  in  1  slave acknowledge

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- In IDLE, a request is `cpu_ce_i & ~flush_i`.
  - `stall_req_o` = request, combinational, so the request cycle itself stalls.
  - On request, register we/adr/sel/dat into the wb_* outputs, set cyc=stb=1, and go to BUSY.
- In BUSY, cyc=stb=1 and all wb_* fields are held constant. `stall_req_o`=1.
  - On `wb_ack_i`: for a read, latch `wb_dat_i` into `cpu_data_o`; for a write, leave `cpu_data_o` unchanged. Clear cyc/stb and go to DONE.
- In DONE, `stall_req_o`=0 and cyc=stb=0, so the CPU advances past the access. Next state is always IDLE; a new request is not accepted in DONE.
- Flush behaviour:
  - `flush_i` in BUSY does not abort the cycle: a write completes to the slave and read data is still latched.
  - `flush_i` in IDLE blocks the start of a cycle.
- `wb_ack_i` seen outside BUSY is ignored.
- Reset mid-cycle: all state returns to IDLE immediately and cyc/stb drop asynchronously. Software owns any side effects.

## Timing
- Reset values: `cpu_data_o`=0, `stall_req_o`=0 (IDLE with no request), `bus_err_o`=0, all wb_* outputs=0, state=IDLE.
- Request in cycle N: cyc/stb high in N+1.
  - With a combinational-ack slave (ack = cyc & stb), ack arrives in N+1, DONE is in N+2, and `cpu_data_o` is valid in N+2.
  - `stall_req_o` is 1 in cycles N and N+1 and 0 in N+2.
- Slave wait states extend BUSY by one cycle each; `stall_req_o` stays 1 throughout.
- Back-to-back requests: the minimum spacing between cyc assertions is 3 cycles (BUSY, DONE, IDLE).
- `cpu_data_o` holds its value until the next read ack.

## Configuration
- WB_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop cyc/stb, set `cpu_data_o`=32'h00000000 for a read, pulse `bus_err_o` in DONE, and go to DONE.
  - An ack in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal completion, no error.
- WB_TIMEOUT_EN undefined:
  - There is no counter, and BUSY waits indefinitely for ack.
  - `bus_err_o` is tied to 0.

## Structure
- State encodings (`WbIdle`, `WbBusy`, `WbDone`, 2-bit), `ZeroWord`, and `RstEnable` go in the shared `defines.v`.
- One natural sub-module is `wb_timeout_cnt` (watchdog counter plus compare). It is instantiated only under `WB_TIMEOUT_EN`.
- The rest is flat: one FSM `always` block and one output-register block.

## Test plan
- Read: cpu_addr_i=32'h0000f020, sel=4'hf, combinational-ack slave returning 32'h000000A5 -> cyc high for exactly 1 cycle, `cpu_data_o`=32'h000000A5 in N+2, stall high for exactly 2 cycles.
- Write: cpu_addr_i=32'h0000f000, data=32'h0000BEEF -> wb_we_o=1, wb_dat_o=32'h0000BEEF, wb_adr_o=32'h0000f000 for one ack cycle, `cpu_data_o` unchanged.
- Wait states: slave delays ack by 3 cycles -> stall high for 5 cycles, wb_* fields stable throughout BUSY.
- Flush: `flush_i`=1 with `cpu_ce_i`=1 in IDLE -> no cyc and no stall. Flush asserted mid-BUSY on a write -> cycle still completes with one ack.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> cyc drops after 4 BUSY cycles, `bus_err_o` pulses 1 cycle, read data=0. The same stimulus without the macro leaves cyc high indefinitely.
- Reset asserted during BUSY -> cyc/stb/stall go 0 asynchronously. After release, the first request runs normally.
